p_loop_sequencer: RTL and testbench

//  Fixed-rate scheduler for the 16-bit proportional motor loop.
//  - On every loop tick it latches setpoint, observed, kp_n and kp_ds.
//  - It runs a 16-cycle shift-add multiply, shifts and clamps the result, then publishes a new signed duty word.
//  - The duty word feeds the 16-bit signed PWM (H-bridge) stage.
//  - It sits between the SPI setpoint / encoder logic and the PWM; it replaces the combinational multiplier with a sequenced one.

---
 rtl/p_ctrl_pkg.sv | 15 +
 rtl/seq_mult16.sv | 51 +++++
 rtl/p_loop_sequencer.sv | 141 ++++++++++++++
 tb/tb_p_loop_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/p_ctrl_pkg.sv
// Shared types and constants for the sequenced motor-control loops.
// Holds the loop FSM encoding and the signed duty saturation limits.
package p_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    CLAMP = 2'd2
  } state_t;

  localparam logic signed [15:0] DUTY_MAX    = 16'sh7FFF;
  localparam logic signed [15:0] DUTY_MIN    = 16'sh8000;
  localparam int                 MULT_CYCLES = 16;

endpackage

// File: rtl/seq_mult16.sv
// Unsigned 16x16 shift-add multiplier, one multiplier bit per cycle.
// done is high during the last step; prod is final on the following cycle.
module seq_mult16
  import p_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_raw,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        done,
  output logic [31:0] prod
);

  logic [31:0] a_sh_reg;
  logic [15:0] b_sh_reg;
  logic [31:0] prod_reg;
  logic [3:0]  cnt_reg;
  logic        running_reg;

  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) begin
      a_sh_reg    <= '0;
      b_sh_reg    <= '0;
      prod_reg    <= '0;
      cnt_reg     <= '0;
      running_reg <= 1'b0;
    end else if (start) begin
      // A new start always wins, even over a multiply still in progress.
      a_sh_reg    <= {16'd0, a};
      b_sh_reg    <= b;
      prod_reg    <= '0;
      cnt_reg     <= '0;
      running_reg <= 1'b1;
    end else if (running_reg) begin
      if (b_sh_reg[0]) begin
        prod_reg <= prod_reg + a_sh_reg;
      end
      a_sh_reg <= a_sh_reg << 1;
      b_sh_reg <= b_sh_reg >> 1;
      cnt_reg  <= cnt_reg + 4'd1;
      if (cnt_reg == 4'(MULT_CYCLES - 1)) begin
        running_reg <= 1'b0;
      end
    end
  end

  assign done = running_reg && (cnt_reg == 4'(MULT_CYCLES - 1));
  assign prod = prod_reg;

endmodule

// File: rtl/p_loop_sequencer.sv
// Fixed-rate proportional loop: on each tick, duty = clamp(kp_n*|sp-obs| >> kp_ds) with the error sign.
// Tick counter, control FSM, sign/shift capture, saturation and registered outputs live here.
module p_loop_sequencer
  import p_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 6000,
  parameter int W        = 16
)
(
  input  logic                clk,
  input  logic                rst_raw,
  input  logic                enable,
  input  logic signed [W-1:0] setpoint,
  input  logic signed [W-1:0] observed,
  input  logic [W-1:0]        kp_n,
  input  logic [3:0]          kp_ds,
  output logic signed [W-1:0] duty,
  output logic                duty_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int CW = $clog2(TICK_DIV);

  generate
    if (TICK_DIV < 20) begin : g_bad_tick_div
      $error("p_loop_sequencer: TICK_DIV must be >= 20");
    end
    if (W != 16) begin : g_bad_width
      $error("p_loop_sequencer: datapath is built around a 16-bit multiplier");
    end
  endgenerate

  state_t              state_reg;
  logic [CW-1:0]       count_reg;
  logic signed [W-1:0] duty_reg;
  logic                duty_valid_reg;
  logic                busy_reg;
  logic                overrun_reg;
  logic                neg_reg;
  logic [3:0]          shift_reg;

  logic                tick;
  logic                start;
  logic [W:0]          err;
  logic [W:0]          err_neg;
  logic [W-1:0]        mag;
  logic                mult_done;
  logic [31:0]         prod;
  logic [31:0]         q;
  logic [15:0]         q_neg;
  logic signed [W-1:0] clamped;

  assign tick  = enable && (count_reg == CW'(TICK_DIV - 1));
  assign start = tick && (state_reg == IDLE) && !busy_reg;

  // One extra bit keeps the difference exact over the full operand range.
  assign err     = {setpoint[W-1], setpoint} - {observed[W-1], observed};
  assign err_neg = -err;
  assign mag     = err[W] ? err_neg[W-1:0] : err[W-1:0];

  seq_mult16 u_mult (
    .clk     (clk),
    .rst_raw (rst_raw),
    .start   (start),
    .a       (kp_n),
    .b       (mag),
    .done    (mult_done),
    .prod    (prod)
  );

  // Shifting the magnitude before reapplying the sign rounds toward zero.
  assign q     = prod >> shift_reg;
  assign q_neg = -q[15:0];

  always_comb begin
    clamped = '0;
    if (!neg_reg) begin
      clamped = (q > 32'd32767) ? DUTY_MAX : q[15:0];
    end else begin
      clamped = (q >= 32'd32768) ? DUTY_MIN : q_neg;
    end
  end

  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      duty_reg       <= '0;
      duty_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
      neg_reg        <= 1'b0;
      shift_reg      <= '0;
    end else if (!enable) begin
      // Halt: abort any computation and announce a zero duty only if it changes.
      state_reg      <= IDLE;
      count_reg      <= '0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
      duty_reg       <= '0;
      duty_valid_reg <= (duty_reg != '0);
    end else begin
      count_reg      <= tick ? '0 : count_reg + CW'(1);
      duty_valid_reg <= 1'b0;
      if (duty_valid_reg) begin
        busy_reg <= 1'b0;
      end
      if (tick && busy_reg) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            neg_reg   <= err[W];
            shift_reg <= kp_ds;
            busy_reg  <= 1'b1;
            state_reg <= MULT;
          end
        end
        MULT: begin
          if (mult_done) begin
            state_reg <= CLAMP;
          end
        end
        CLAMP: begin
          duty_reg       <= clamped;
          duty_valid_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign duty       = duty_reg;
  assign duty_valid = duty_valid_reg;
  assign busy       = busy_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_p_loop_sequencer.sv
// Directed bench for p_loop_sequencer with a 32-cycle control period.
// Table-driven duty vectors followed by reset, mid-flight, enable and overrun sequences.
module tb_p_loop_sequencer;

  localparam int TICK_DIV = 32;
  localparam int LIMIT    = 3 * TICK_DIV;

  logic               clk;
  logic               rst_raw;
  logic               enable;
  logic signed [15:0] setpoint;
  logic signed [15:0] observed;
  logic [15:0]        kp_n;
  logic [3:0]         kp_ds;
  logic signed [15:0] duty;
  logic               duty_valid;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  p_loop_sequencer #(.TICK_DIV(TICK_DIV), .W(16)) dut (
    .clk        (clk),
    .rst_raw    (rst_raw),
    .enable     (enable),
    .setpoint   (setpoint),
    .observed   (observed),
    .kp_n       (kp_n),
    .kp_ds      (kp_ds),
    .duty       (duty),
    .duty_valid (duty_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] sp;
    logic signed [15:0] ob;
    logic [15:0]        kn;
    logic [3:0]         ds;
    logic signed [15:0] exp_duty;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int busy_at, output int valid_at, output bit timeout);
    int n;
    n = 0;
    busy_at = -1;
    valid_at = -1;
    timeout = 1'b0;
    while (1) begin
      @(negedge clk);
      n++;
      if (busy && busy_at < 0) busy_at = n;
      if (duty_valid) begin
        valid_at = n;
        break;
      end
      if (n >= LIMIT) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_busy(output int busy_at, output bit timeout);
    int n;
    n = 0;
    busy_at = -1;
    timeout = 1'b0;
    while (1) begin
      @(negedge clk);
      n++;
      if (busy) begin
        busy_at = n;
        break;
      end
      if (n >= LIMIT) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_inputs(input logic signed [15:0] sp, input logic signed [15:0] ob,
                            input logic [15:0] kn, input logic [3:0] ds);
    setpoint = sp;
    observed = ob;
    kp_n     = kn;
    kp_ds    = ds;
  endtask

  initial begin
    int bat, vat;
    bit to;

    vecs[0]  = '{-16'sd512,  16'sd0,     16'd315,   4'd2,  16'sh8000};
    vecs[1]  = '{16'sd100,   16'sd40,    16'd3,     4'd1,  16'sd90};
    vecs[2]  = '{16'sd40,    16'sd100,   16'd3,     4'd1,  -16'sd90};
    vecs[3]  = '{16'sd0,     16'sd61,    16'd1,     4'd1,  -16'sd30};
    vecs[4]  = '{16'sh7FFF,  16'sh8000,  16'd65535, 4'd0,  16'sh7FFF};
    vecs[5]  = '{16'sh8000,  16'sh7FFF,  16'd65535, 4'd0,  16'sh8000};
    vecs[6]  = '{16'sd1234,  16'sd1234,  16'd777,   4'd3,  16'sd0};
    vecs[7]  = '{16'sd500,   -16'sd300,  16'd0,     4'd0,  16'sd0};
    vecs[8]  = '{16'sd500,   16'sd0,     16'd1,     4'd0,  16'sd500};
    vecs[9]  = '{16'sd200,   16'sd0,     16'd327,   4'd1,  16'sd32700};
    vecs[10] = '{16'sd0,     16'sd128,   16'd256,   4'd0,  16'sh8000};
    vecs[11] = '{16'sd128,   16'sd0,     16'd256,   4'd0,  16'sh7FFF};
    vecs[12] = '{16'sd1000,  16'sd0,     16'd40000, 4'd15, 16'sd1220};
    vecs[13] = '{16'sd0,     16'sd1000,  16'd40000, 4'd15, -16'sd1220};

    rst_raw = 1'b0;
    enable  = 1'b1;
    set_inputs(vecs[0].sp, vecs[0].ob, vecs[0].kn, vecs[0].ds);
    repeat (3) @(negedge clk);
    check("reset_duty", duty, 0);
    check("reset_valid", duty_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    rst_raw = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      set_inputs(vecs[i].sp, vecs[i].ob, vecs[i].kn, vecs[i].ds);
      wait_valid(bat, vat, to);
      check($sformatf("vec%0d_timeout", i), to, 0);
      check($sformatf("vec%0d_duty", i), duty, vecs[i].exp_duty);
      check($sformatf("vec%0d_latency", i), vat - bat, 17);
      check($sformatf("vec%0d_busy_at_valid", i), busy, 1);
      $display("vec %0d sp=%0d ob=%0d kp_n=%0d kp_ds=%0d duty=%0d latency=%0d",
               i, vecs[i].sp, vecs[i].ob, vecs[i].kn, vecs[i].ds, duty, vat - bat);
      @(negedge clk);
      check($sformatf("vec%0d_pulse_width", i), duty_valid, 0);
      check($sformatf("vec%0d_busy_clear", i), busy, 0);
    end

    // Setpoint changed mid-flight: current result uses the old value.
    set_inputs(16'sd100, 16'sd40, 16'd3, 4'd1);
    wait_busy(bat, to);
    check("midflight_busy_timeout", to, 0);
    repeat (4) @(negedge clk);
    setpoint = 16'sd200;
    wait_valid(bat, vat, to);
    check("midflight_old_duty", duty, 90);
    $display("midflight in-flight duty=%0d", duty);
    wait_valid(bat, vat, to);
    check("midflight_new_duty", duty, 240);
    $display("midflight next-period duty=%0d", duty);

    // Asynchronous reset during MULT, then restart timing.
    wait_busy(bat, to);
    repeat (7) @(negedge clk);
    rst_raw = 1'b0;
    #1;
    check("async_rst_duty", duty, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", duty_valid, 0);
    repeat (3) @(negedge clk);
    rst_raw = 1'b1;
    wait_busy(bat, to);
    check("restart_busy_at", bat, TICK_DIV);
    wait_valid(bat, vat, to);
    check("restart_duty", duty, 240);
    $display("reset restart busy_after=%0d duty=%0d", TICK_DIV, duty);

    // Enable dropped during CLAMP while duty=500.
    @(negedge clk);
    set_inputs(16'sd500, 16'sd0, 16'd1, 4'd0);
    wait_valid(bat, vat, to);
    check("pre_abort_duty", duty, 500);
    wait_busy(bat, to);
    repeat (16) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_duty", duty, 0);
    check("abort_valid", duty_valid, 1);
    check("abort_busy", busy, 0);
    @(negedge clk);
    check("abort_no_repeat", duty_valid, 0);
    $display("abort in clamp duty=%0d", duty);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_busy(bat, to);
    check("enable_rise_busy_at", bat, TICK_DIV);
    wait_valid(bat, vat, to);
    check("enable_rise_duty", duty, 500);

    // Forced back-to-back ticks produce a sticky overrun.
    @(negedge clk);
    check("overrun_before", overrun, 0);
    force dut.tick = 1'b1;
    repeat (3) @(negedge clk);
    release dut.tick;
    check("overrun_set", overrun, 1);
    wait_valid(bat, vat, to);
    check("overrun_duty", duty, 500);
    check("overrun_sticky", overrun, 1);
    $display("overrun forced overrun=%0b duty=%0d", overrun, duty);
    enable = 1'b0;
    @(negedge clk);
    check("overrun_cleared", overrun, 0);
    check("disable_duty", duty, 0);
    enable = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
